// File: rtl/logic_gate_unit.sv
// logic_gate_unit: selectable bitwise logic stage (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS)
// feeding a DEPTH-entry result FIFO with valid/ready handshake on both sides.
// Optional macro LOGIC_GATE_UNIT_FLAGS_EN enables the zero/ones/parity head flags;
// without it the flag ports are tied to 0.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     out_zero,
    output logic                     out_ones,
    output logic                     out_parity,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_result;
    logic             w_push;
    logic             w_pop;

    // Ready/valid come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out       = out_valid ? r_mem[r_rptr] : '0;

    // Bitwise operation select; NOT and PASS use in_a only.
    always_comb begin
        w_result = '0;
        case (in_op)
            3'd0: w_result = in_a & in_b;
            3'd1: w_result = in_a | in_b;
            3'd2: w_result = in_a ^ in_b;
            3'd3: w_result = ~(in_a & in_b);
            3'd4: w_result = ~(in_a | in_b);
            3'd5: w_result = ~(in_a ^ in_b);
            3'd6: w_result = ~in_a;
            3'd7: w_result = in_a;
            default: w_result = '0;
        endcase
    end

    // Result storage; contents survive reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wptr] <= w_result;
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    assign out_zero   = out_valid && (out == '0);
    assign out_ones   = out_valid && (&out);
    assign out_parity = out_valid && (^out);
`else
    assign out_zero   = 1'b0;
    assign out_ones   = 1'b0;
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit (WIDTH=8, DEPTH=4).
module tb_logic_gate_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic       out_zero, out_ones, out_parity;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic_gate_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    endtask

    logic [7:0] exp_ops [8];

    initial begin
        exp_ops[0] = 8'hC0; exp_ops[1] = 8'hFC; exp_ops[2] = 8'h3C; exp_ops[3] = 8'h3F;
        exp_ops[4] = 8'h03; exp_ops[5] = 8'hC3; exp_ops[6] = 8'h0F; exp_ops[7] = 8'hF0;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'({out_zero, out_ones, out_parity}), 32'd0);

        // All eight operations, one cycle latency, streaming
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            drive(3'(op), 8'hF0, 8'hCC);
            step();
            chk($sformatf("op%0d_out", op), 32'(out), 32'(exp_ops[op]));
            chk($sformatf("op%0d_valid", op), 32'(out_valid), 32'd1);
            chk($sformatf("op%0d_ready", op), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("ops_drained", 32'(count), 32'd0);

        // Fill with consumer stalled, fifth beat held
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(3'd0, 8'(i), 8'hFF);
            chk($sformatf("fill_ready%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
            if (i <= 4) step();
        end
        chk("fill_count", 32'(count), 32'd4);
        step();
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_hold_out", 32'(out), 32'h01);
        out_ready = 1'b1;
        step();
        chk("full_pop_count", 32'(count), 32'd3);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        chk("drain_02", 32'(out), 32'h02);
        step();
        in_valid = 1'b0;
        chk("accept5_count", 32'(count), 32'd3);
        chk("drain_03", 32'(out), 32'h03);
        step();
        chk("drain_04", 32'(out), 32'h04);
        step();
        chk("drain_05", 32'(out), 32'h05);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Full with push+pop same cycle: pop only
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 8'(8'h10 + i), 8'h00);
            step();
        end
        drive(3'd7, 8'h99, 8'h00);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpp_count", 32'(count), 32'd3);
        chk("fullpp_ready", 32'(in_ready), 32'd1);
        chk("fullpp_11", 32'(out), 32'h11);
        step();
        chk("fullpp_12", 32'(out), 32'h12);
        step();
        chk("fullpp_13", 32'(out), 32'h13);
        step();
        chk("fullpp_empty", 32'(count), 32'd0);

        // Sustained push/pop at count=2 across pointer wrap
        out_ready = 1'b0;
        drive(3'd7, 8'h20, 8'h00); step();
        drive(3'd7, 8'h21, 8'h00); step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'd7, 8'(8'h22 + i), 8'h00);
            chk($sformatf("stream_out%0d", i), 32'(out), 32'(8'h20 + i));
            chk($sformatf("stream_cnt%0d", i), 32'(count), 32'd2);
            step();
        end
        in_valid = 1'b0;
        chk("stream_tail0", 32'(out), 32'h2A);
        step();
        chk("stream_tail1", 32'(out), 32'h2B);
        step();
        chk("stream_empty", 32'(count), 32'd0);

        // Flags
        out_ready = 1'b0;
        drive(3'd2, 8'h5A, 8'h5A); step(); in_valid = 1'b0;
        chk("xor_out", 32'(out), 32'h00);
        chk("xor_flags", 32'({out_zero, out_ones, out_parity}), 32'({FL, 1'b0, 1'b0}));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("empty_flags", 32'({out_zero, out_ones, out_parity}), 32'd0);
        drive(3'd4, 8'h00, 8'h00); step(); in_valid = 1'b0;
        chk("nor_out", 32'(out), 32'hFF);
        chk("nor_flags", 32'({out_zero, out_ones, out_parity}), 32'({1'b0, FL, 1'b0}));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        drive(3'd7, 8'h07, 8'h00); step(); in_valid = 1'b0;
        chk("pass_out", 32'(out), 32'h07);
        chk("pass_flags", 32'({out_zero, out_ones, out_parity}), 32'({1'b0, 1'b0, FL}));
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Reset mid-operation with a push offered in the reset cycle
        for (int i = 0; i < 3; i++) begin
            drive(3'd7, 8'(8'h31 + i), 8'h00);
            step();
        end
        chk("prerst_count", 32'(count), 32'd3);
        drive(3'd7, 8'h77, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        step();
        chk("postrst_count", 32'(count), 32'd0);
        drive(3'd7, 8'h44, 8'h00); step(); in_valid = 1'b0;
        chk("postrst_out", 32'(out), 32'h44);
        chk("postrst_cnt1", 32'(count), 32'd1);
        out_ready = 1'b1; step();
        chk("postrst_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered successor to the single-bit gate cells: applies one of eight bitwise logic operations to two WIDTH-bit operands and queues results in a small output FIFO behind a valid/ready handshake. It sits between an operand producer and a result consumer that may stall. It replaces discrete per-gate instances wherever a selectable, flow-controlled logic stage is needed.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 4, result FIFO entries (power of two, ≥2)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit can accept a beat this cycle
- in_op  input  3  operation select (see Operation)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result at FIFO head is valid
- out_ready  input  1  consumer takes head this cycle
- out  output  WIDTH  head result
- out_zero  output  1  head result is all zeros
- out_ones  output  1  head result is all ones
- out_parity  output  1  XOR-reduction of head result
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- in_op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT in_a (in_b ignored), 7 PASS in_a.
- Result computed bitwise, full WIDTH, no carries; no width extension or truncation.
- Push: in_valid && in_ready. Result of the in_op/in_a/in_b sampled that cycle is written to FIFO tail.
- Pop: out_valid && out_ready. Head entry is discarded.
- in_ready = (count != DEPTH). Depends only on registered state, never on out_ready (no combinational ready path).
- out_valid = (count != 0).
- out forced to 0 whenever out_valid = 0; otherwise equals head entry.
- Simultaneous push and pop while 0 < count < DEPTH: both occur, count unchanged, order preserved.
- count = 0 and push and out_ready high: no bypass; entry written, popped no earlier than next cycle.
- count = DEPTH: push refused even if out_ready high that cycle; pop proceeds, in_ready rises next cycle.
- Read/write pointers wrap modulo DEPTH; order strictly FIFO across wrap.
- in_valid while in_ready low: beat not consumed, no state change; producer holds the beat.
- Unknown/X in_op never occurs at a push; no defined result required.

## Timing
- Latency: push in cycle N → out_valid high and out valid in cycle N+1 (when FIFO was empty).
- Throughput: one push and one pop per cycle sustained.
- Reset (rst high at a rising edge): count = 0, pointers = 0, out_valid = 0, out = 0, out_zero/out_ones/out_parity = 0, in_ready = 1 from the cycle after reset. FIFO contents need not be cleared.
- Reset mid-operation: all queued results discarded; any push or pop in the reset cycle is ignored.
- Flags are combinational from the head entry and FIFO state; they change in the same cycle as out.

## Configuration
- LOGIC_GATE_UNIT_FLAGS_EN defined: out_zero = out_valid && (out == 0); out_ones = out_valid && (&out); out_parity = out_valid && (^out).
- Not defined: out_zero, out_ones, out_parity tied to constant 0; no reduction logic synthesised. Ports remain present in both builds.

## Test plan
(WIDTH=8, DEPTH=4, flags macro defined unless noted)
- Reset, then push each in_op 0-7 with in_a=8'hF0, in_b=8'hCC, out_ready=1 → out sequence C0, FC, 3C, 3F, 03, C3, 0F, F0, each one cycle after its push, in_ready stays 1.
- out_ready=0, push 5 beats of AND with in_a=8'h01..8'h05, in_b=8'hFF → first 4 accepted, count=4, in_ready=0 on 5th; raise out_ready → 01,02,03,04 popped in order, then 5th beat accepted.
- Fill to 4, then push and out_ready together for one cycle → pop occurs, push refused, count=3, in_ready=1 next cycle.
- Continuous push/pop for 10 beats at count=2 → count stays 2, all 10 results in order across pointer wrap.
- Push XOR in_a=in_b=8'h5A → out=00, out_zero=1, out_ones=0, out_parity=0; push NOR 8'h00,8'h00 → out=FF, out_ones=1; push PASS 8'h07 → out_parity=1. Without macro: all three flags 0.
- Fill 3 entries, assert rst one cycle with in_valid=1 → count=0, out_valid=0, out=0 next cycle; no stale data appears afterwards.
